// File: rtl/psum_mem_ctrl.sv
// Partial-sum RAM responder: fixed-latency reads, write-first collisions,
// zero-fill clear sequence and a sticky out-of-range address flag.
module psum_mem_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter int MEM_DELAY     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl_wadd,
    input  logic                  memctrl_wren,
    input  logic [DATA_WIDTH-1:0] memctrl_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl_radd,
    input  logic                  memctrl_rden,
    output logic [DATA_WIDTH-1:0] memctrl_odat,
    output logic                  memctrl_oval,
    input  logic                  i_clear_start,
    output logic                  o_clear_busy,
    output logic                  o_clear_done,
    output logic                  o_oob_err
);

    localparam int DEPTH = 2 ** MEM_ADDR_BITS;
    localparam logic [MEM_ADDR_BITS:0] LAST_IDX = (MEM_ADDR_BITS + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [MEM_ADDR_BITS:0] clr_idx;
    logic [MEM_ADDR_BITS:0] clr_idx_nxt;
    logic                   in_clear;
    logic                   clr_we;
    logic                   done;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [MEM_ADDR_BITS-1:0] widx;
    logic [MEM_ADDR_BITS-1:0] ridx;
    logic                     wr_acc;
    logic                     rd_acc;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic                     w_oob;
    logic                     r_oob;

    logic [MEM_DELAY-1:0]  vld;
    logic [DATA_WIDTH-1:0] dat [MEM_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        in_clear    = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_clear_start) begin
                    state_nxt   = CLEAR;
                    clr_idx_nxt = '0;
                end
            end
            CLEAR: begin
                in_clear    = 1'b1;
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_clear_busy = in_clear;
    assign o_clear_done = done;

    // A reset edge abandons the clear without one more zero write
    assign clr_we = in_clear && !rst;
    assign wr_acc = memctrl_wren && !in_clear;
    assign rd_acc = memctrl_rden && !in_clear;
    assign widx   = memctrl_wadd[MEM_ADDR_BITS-1:0];
    assign ridx   = memctrl_radd[MEM_ADDR_BITS-1:0];

    // Write-first: a same-edge write to the read index bypasses the array
    assign rd_word = (wr_acc && (widx == ridx)) ? memctrl_idat : mem[ridx];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx[MEM_ADDR_BITS-1:0]] <= '0;
        end else if (wr_acc) begin
            mem[widx] <= memctrl_idat;
        end
    end

    assign w_oob = |memctrl_wadd[ADDR_WIDTH-1:MEM_ADDR_BITS];
    assign r_oob = |memctrl_radd[ADDR_WIDTH-1:MEM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            o_oob_err <= 1'b0;
        end else if ((memctrl_wren && w_oob) || (memctrl_rden && r_oob)) begin
            o_oob_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld[0] <= 1'b0;
            dat[0] <= '0;
        end else begin
            vld[0] <= rd_acc;
            if (rd_acc) begin
                dat[0] <= rd_word;
            end
        end
    end

    for (genvar s = 1; s < MEM_DELAY; s++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                vld[s] <= 1'b0;
                dat[s] <= '0;
            end else begin
                vld[s] <= vld[s-1];
                dat[s] <= dat[s-1];
            end
        end
    end

    assign memctrl_oval = vld[MEM_DELAY-1];
    assign memctrl_odat = dat[MEM_DELAY-1];

endmodule

// File: tb/tb_psum_mem_ctrl.sv
// Bench: two instances (read latency 1 and 3) on shared stimulus, checked
// against a cycle-numbered reference model of the RAM and clear schedule.
module tb_psum_mem_ctrl;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wadd;
    logic        wren;
    logic [31:0] idat;
    logic [31:0] radd;
    logic        rden;
    logic        start;

    logic [31:0] odat1, odat3;
    logic        oval1, oval3;
    logic        busy1, busy3;
    logic        done1, done3;
    logic        oob1, oob3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    psum_mem_ctrl #(.MEM_DELAY(1)) dut1 (
        .clk(clk), .rst(rst),
        .memctrl_wadd(wadd), .memctrl_wren(wren), .memctrl_idat(idat),
        .memctrl_radd(radd), .memctrl_rden(rden),
        .memctrl_odat(odat1), .memctrl_oval(oval1),
        .i_clear_start(start), .o_clear_busy(busy1),
        .o_clear_done(done1), .o_oob_err(oob1)
    );

    psum_mem_ctrl #(.MEM_DELAY(3)) dut3 (
        .clk(clk), .rst(rst),
        .memctrl_wadd(wadd), .memctrl_wren(wren), .memctrl_idat(idat),
        .memctrl_radd(radd), .memctrl_rden(rden),
        .memctrl_odat(odat3), .memctrl_oval(oval3),
        .i_clear_start(start), .o_clear_busy(busy3),
        .o_clear_done(done3), .o_oob_err(oob3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: edge number e, clear started at edge c0 zeroes
    // index j-1 at edge c0+j for j=1..DEPTH; requests on those edges drop.
    logic [31:0] mem_m [DEPTH];
    bit          rv [8];
    logic [31:0] rd [8];
    int          cyc = 0;
    int          c0 = 0;
    bit          clr_on = 0;
    bit          oob_m = 0;
    bit          exp_busy = 0;
    bit          exp_done = 0;
    bit          bz;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            clr_on = 0;
            oob_m = 0;
            exp_busy = 0;
            exp_done = 0;
            for (int j = 0; j < 3; j++) rv[(cyc - j) & 7] = 0;
        end else begin
            bz = clr_on && cyc > c0 && cyc <= c0 + DEPTH;
            rv[cyc & 7] = 0;
            if ((wren && (wadd >> 10) != 0) || (rden && (radd >> 10) != 0))
                oob_m = 1;
            if (bz) begin
                mem_m[cyc - c0 - 1] = '0;
            end else begin
                if (wren) mem_m[wadd % DEPTH] = idat;
                if (rden) begin
                    rv[cyc & 7] = 1;
                    rd[cyc & 7] = mem_m[radd % DEPTH];
                end
            end
            if (start && !(clr_on && cyc <= c0 + DEPTH + 1)) begin
                clr_on = 1;
                c0 = cyc;
            end
            exp_busy = clr_on && cyc >= c0 && cyc < c0 + DEPTH;
            exp_done = clr_on && cyc == c0 + DEPTH;
        end
    end

    int k1, k3;
    always @(negedge clk) begin
        if (cyc > 0) begin
            k1 = cyc & 7;
            k3 = (cyc - 2) & 7;
            chk("oval1", {31'b0, oval1}, {31'b0, rv[k1]});
            if (rv[k1]) chk("odat1", odat1, rd[k1]);
            chk("oval3", {31'b0, oval3}, {31'b0, rv[k3]});
            if (rv[k3]) chk("odat3", odat3, rd[k3]);
            chk("busy1", {31'b0, busy1}, {31'b0, exp_busy});
            chk("busy3", {31'b0, busy3}, {31'b0, exp_busy});
            chk("done1", {31'b0, done1}, {31'b0, exp_done});
            chk("done3", {31'b0, done3}, {31'b0, exp_done});
            chk("oob1", {31'b0, oob1}, {31'b0, oob_m});
            chk("oob3", {31'b0, oob3}, {31'b0, oob_m});
        end
    end

    task automatic idle();
        wren = 0; rden = 0; start = 0; rst = 0;
        wadd = '0; radd = '0; idat = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < DEPTH + 50 && !seen; i++) begin
            step();
            if (done1) seen = 1;
        end
        chk(tag, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_odat1", odat1, 32'd0);
        chk("rst_odat3", odat3, 32'd0);
        chk("rst_busy", {31'b0, busy1}, 32'd0);
        idle();
        step();

        // Full clear with dropped requests and an ignored restart mid-way
        start = 1;
        step();
        repeat (100) step();
        wren = 1; wadd = 3; idat = 32'hDEADBEEF;
        rden = 1; radd = 3; start = 1;
        step();
        wait_done("clear1_done");
        step();
        for (int a = 0; a < DEPTH; a++) begin
            rden = 1; radd = a;
            step();
        end
        repeat (4) step();

        // Fixed latency read after write
        wren = 1; wadd = 5; idat = 32'h04030201;
        step();
        rden = 1; radd = 5;
        step();
        repeat (4) step();

        // Same-edge write-first, then a later write must not disturb it
        wren = 1; wadd = 7; idat = 32'hAABBCCDD; rden = 1; radd = 7;
        step();
        wren = 1; wadd = 7; idat = 32'h11223344;
        step();
        repeat (4) step();

        // Accumulator stream: reads 0..15, write-back lagging by 2
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin rden = 1; radd = i; end
            if (i >= 2) begin wren = 1; wadd = i - 2; idat = $urandom; end
            step();
        end
        repeat (4) step();

        // Random traffic over a small window to force collisions
        for (int i = 0; i < 400; i++) begin
            wren = 1'($urandom_range(0, 1));
            wadd = $urandom_range(0, 31);
            idat = $urandom;
            rden = 1'($urandom_range(0, 1));
            radd = $urandom_range(0, 31);
            step();
        end
        repeat (4) step();

        // Out-of-range address aliases to index 0 and sets the sticky flag
        rden = 1; radd = 32'h0000_0400;
        step();
        repeat (10) step();
        chk("oob_sticky", {31'b0, oob1}, 32'd1);

        // Reset with a read in flight flushes it
        rden = 1; radd = 1;
        step();
        rst = 1;
        step();
        repeat (4) step();

        // Reset mid-clear abandons it
        start = 1;
        step();
        repeat (50) step();
        rst = 1;
        step();
        chk("rst_mid_busy", {31'b0, busy1}, 32'd0);
        chk("rst_mid_oob", {31'b0, oob3}, 32'd0);
        repeat (3) step();

        // A fresh clear after the abandoned one runs to completion
        start = 1;
        step();
        wait_done("clear2_done");
        for (int a = 0; a < 64; a++) begin
            rden = 1; radd = $urandom_range(0, DEPTH - 1);
            step();
        end
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
